// File: rtl/tow_pkg.sv
// tow_pkg: arbiter FSM state encoding (WAIT_REL/ARMED/DECIDED) and default DB_CYCLES
package tow_pkg;
   typedef enum logic [1:0] {WAIT_REL = 2'b00, ARMED = 2'b01, DECIDED = 2'b10} state_t;
   localparam int DB_CYCLES_DEF = 16;
endpackage

// File: rtl/pb_debounce.sv
// pb_debounce: one button, 2-flop sync -> debounce (PB_ARBITER_DEBOUNCE_EN, else passthrough) -> registered press pulse; ports clk, rst, pb in; sync, level, press out
module pb_debounce import tow_pkg::*; #(
   parameter int DB_CYCLES = DB_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic pb,
   output logic sync,
   output logic level,
   output logic press
);
   logic s1, lvl_d;
   if (DB_CYCLES < 2 || DB_CYCLES > 65535) begin : g_range
      $error("pb_debounce: DB_CYCLES out of range");
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         sync <= 1'b0;
         lvl_d <= 1'b0;
         press <= 1'b0;
      end else begin
         s1 <= pb;
         sync <= s1;
         lvl_d <= level;
         press <= level & ~lvl_d;
      end
   end
`ifdef PB_ARBITER_DEBOUNCE_EN
   localparam int CW = $clog2(DB_CYCLES + 1);
   logic [CW-1:0] cnt;
   always_ff @(posedge clk) begin
      if (rst) begin
         level <= 1'b0;
         cnt <= '0;
      end else if (sync == level) begin
         cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
         level <= sync;
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
`else
   assign level = sync;
`endif
endmodule

// File: rtl/pb_arbiter.sv
// pb_arbiter: two-button first-press arbiter (PB_ARBITER_DEBOUNCE_EN enables debounce); ports clk, rst, pbl, pbr, clr in; push, right, tie out; arms only once the sync pipeline has filled and both buttons read released
module pb_arbiter import tow_pkg::*; #(
   parameter int DB_CYCLES = DB_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic pbl,
   input  logic pbr,
   input  logic clr,
   output logic push,
   output logic right,
   output logic tie
);
   logic sl, sr, ll, lr, el, er, idle;
   logic [1:0] rdy;
   state_t st;
   pb_debounce #(.DB_CYCLES(DB_CYCLES)) u_l (.clk(clk), .rst(rst), .pb(pbl), .sync(sl), .level(ll), .press(el));
   pb_debounce #(.DB_CYCLES(DB_CYCLES)) u_r (.clk(clk), .rst(rst), .pb(pbr), .sync(sr), .level(lr), .press(er));
   assign idle = rdy[1] & ~(sl | sr | ll | lr);
   always_ff @(posedge clk) begin
      if (rst) begin
         st <= WAIT_REL;
         push <= 1'b0;
         right <= 1'b0;
         tie <= 1'b0;
         rdy <= '0;
      end else begin
         rdy <= {rdy[0], 1'b1};
         if (clr) begin
            st <= WAIT_REL;
            push <= 1'b0;
            right <= 1'b0;
            tie <= 1'b0;
         end else if (st == WAIT_REL) begin
            st <= idle ? ARMED : WAIT_REL;
         end else if (st == ARMED && (el | er)) begin
            st <= DECIDED;
            push <= 1'b1;
            right <= er & ~el;
            tie <= el & er;
         end
      end
   end
endmodule

// File: doc/pb_arbiter.md
PB_ARBITER -- requirements
Module: pb_arbiter

Interface
REQ-001 Parameter: DB_CYCLES, default 16, number of consecutive stable cycles required to accept a debounced level change (range 2..65535).
REQ-002 Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- pbl  input  1  left player push button, asynchronous, active-high.
- pbr  input  1  right player push button, asynchronous, active-high.
- clr  input  1  round clear from the game controller; synchronous, single-cycle or held.
- push  output  1  a press has been decided this round; held until clr or rst.
- right  output  1  right player pressed first; valid only while push=1.
- tie  output  1  both players pressed in the same cycle; valid only while push=1.

Function
REQ-003 Each button SHALL pass through its own two-flop synchronizer before any other use.
REQ-004 Each synchronized button SHALL feed a debouncer whose output level changes only after the synchronized level has differed from it for DB_CYCLES consecutive cycles; any mismatch break restarts the count.
REQ-005 A press event SHALL be a single-cycle pulse on a 0->1 transition of the debounced level; releases generate no event.
REQ-006 The arbiter FSM SHALL have states WAIT_REL, ARMED, DECIDED.
REQ-007 WAIT_REL -> ARMED when both debounced levels are 0; press events in WAIT_REL are ignored.
REQ-008 ARMED, left event only -> DECIDED with push=1, right=0, tie=0.
REQ-009 ARMED, right event only -> DECIDED with push=1, right=1, tie=0.
REQ-010 ARMED, both events same cycle -> DECIDED with push=1, tie=1, right=0.
REQ-011 DECIDED SHALL ignore all further events; outputs hold until clr.
REQ-012 clr=1 in any state SHALL force WAIT_REL and clear push, right, tie on the next edge; clr wins over a simultaneous press event.
REQ-013 Outputs SHALL be registered; push rises on the edge after the press event cycle.
REQ-014 Latency: a clean press first sampled high at edge N SHALL raise push at edge N+DB_CYCLES+3 (with DEBOUNCE_EN); N+3 without.
REQ-015 A button held through clr SHALL NOT produce a decision until released and pressed again.
REQ-016 Debounce counters SHALL saturate at DB_CYCLES, never wrap.

Reset
REQ-017 rst SHALL set: FSM=WAIT_REL, push=0, right=0, tie=0, synchronizer flops=0, debounced levels=0, counters=0.
REQ-018 rst mid-round SHALL discard any pending count or decision; a button still held after reset SHALL be treated as per REQ-015.

Configuration
REQ-019 Macro PB_ARBITER_DEBOUNCE_EN: defined -> debouncers per REQ-004; undefined -> debounced level equals synchronized level directly, no counters instantiated, DB_CYCLES ignored.

Structure
REQ-020 Shared package tow_pkg SHALL hold the FSM state encoding (WAIT_REL=2'b00, ARMED=2'b01, DECIDED=2'b10) and the DB_CYCLES default constant.
REQ-021 One sub-module pb_debounce (synchronizer + debouncer + edge pulse, one button) SHALL be instantiated twice.

Verification
REQ-022 DB_CYCLES=4, debounce on: after reset, clr pulse, pbl held high from edge 10 -> push=1, right=0, tie=0 at edge 17; stays until clr.
REQ-023 pbr high 5 cycles, pbl high 6 cycles later -> right=1, tie=0; pbl event ignored.
REQ-024 pbl and pbr rise on same edge, clean -> push=1, tie=1, right=0.
REQ-025 pbl toggles every 2 cycles for 20 cycles, DB_CYCLES=4 -> push stays 0 throughout.
REQ-026 pbr held high across clr -> FSM WAIT_REL, push=0; release then press again -> push=1, right=1.
REQ-027 clr asserted same cycle as a left press event -> push=0 next edge; FSM=WAIT_REL.
